// File: rtl/downsample_pack_fifo.sv
// Narrow-to-wide packing FIFO: pairs DATA_IN half-words (first half low) into DATA_OUT words.
// Optional macro DOWNSAMPLE_FIFO_FLUSH_EN lets i_flush push a lone pending half, zero-padded.
module downsample_pack_fifo #(
  parameter int DATA_IN               = 128,
  parameter int DATA_OUT              = 256,
  parameter int DEPTH                 = 10,
  parameter int ALMOST_FULL_THRESHOLD = 1000
) (
  input  logic                system_clk,
  input  logic                rst_n,
  input  logic                i_wren,
  input  logic [DATA_IN-1:0]  i_wrdata,
  input  logic                i_flush,
  output logic                o_full,
  output logic                o_almost_full,
  output logic                o_half_pending,
  input  logic                i_rden,
  output logic [DATA_OUT-1:0] o_rddata,
  output logic                o_rdvalid,
  output logic                o_empty,
  output logic                o_almost_empty,
  input  logic [DEPTH:0]      almost_empty_threshold,
  output logic [DEPTH:0]      o_count
);

  localparam int unsigned      WORDS      = 2 ** DEPTH;
  localparam logic [DEPTH:0]   FULL_COUNT = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0]   AF_COUNT   = ALMOST_FULL_THRESHOLD[DEPTH:0];

  logic [DATA_OUT-1:0] mem [WORDS];

  logic [DEPTH-1:0]    wrptr_q, wrptr_d;
  logic [DEPTH-1:0]    rdptr_q, rdptr_d;
  logic [DEPTH:0]      count_q, count_d;
  logic [DATA_IN-1:0]  half_q, half_d;
  logic                half_pending_q, half_pending_d;
  logic [DATA_OUT-1:0] rddata_q, rddata_d;
  logic                rdvalid_q, rdvalid_d;

  logic                full, empty;
  logic                wr_acc, rd_acc, word_wr;
  logic [DATA_OUT-1:0] word_data;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

`ifndef DOWNSAMPLE_FIFO_FLUSH_EN
  logic unused_flush;
  assign unused_flush = i_flush;
`endif

  always_comb begin
    wr_acc         = i_wren && !full;
    rd_acc         = i_rden && !empty;
    half_d         = half_q;
    half_pending_d = half_pending_q;
    word_wr        = 1'b0;
    word_data      = {i_wrdata, half_q};

    if (wr_acc) begin
      if (half_pending_q) begin
        word_wr        = 1'b1;
        word_data      = {i_wrdata, half_q};
        half_pending_d = 1'b0;
      end
`ifdef DOWNSAMPLE_FIFO_FLUSH_EN
      else if (i_flush) begin
        // A flushed lone write bypasses the pack register entirely.
        word_wr   = 1'b1;
        word_data = {{DATA_IN{1'b0}}, i_wrdata};
      end
`endif
      else begin
        half_d         = i_wrdata;
        half_pending_d = 1'b1;
      end
    end
`ifdef DOWNSAMPLE_FIFO_FLUSH_EN
    else if (i_flush && half_pending_q && !full) begin
      word_wr        = 1'b1;
      word_data      = {{DATA_IN{1'b0}}, half_q};
      half_pending_d = 1'b0;
    end
`endif

    wrptr_d = word_wr ? wrptr_q + 1'b1 : wrptr_q;
    rdptr_d = rd_acc  ? rdptr_q + 1'b1 : rdptr_q;

    case ({word_wr, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    rdvalid_d = rd_acc;
    rddata_d  = rd_acc ? mem[rdptr_q] : rddata_q;
  end

  // Storage carries no reset; pointers and count alone define what is valid.
  always_ff @(posedge system_clk) begin
    if (word_wr) begin
      mem[wrptr_q] <= word_data;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wrptr_q        <= '0;
      rdptr_q        <= '0;
      count_q        <= '0;
      half_q         <= '0;
      half_pending_q <= 1'b0;
      rddata_q       <= '0;
      rdvalid_q      <= 1'b0;
    end else begin
      wrptr_q        <= wrptr_d;
      rdptr_q        <= rdptr_d;
      count_q        <= count_d;
      half_q         <= half_d;
      half_pending_q <= half_pending_d;
      rddata_q       <= rddata_d;
      rdvalid_q      <= rdvalid_d;
    end
  end

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count_q >= AF_COUNT);
  assign o_almost_empty = (count_q < almost_empty_threshold);
  assign o_half_pending = half_pending_q;
  assign o_count        = count_q;
  assign o_rddata       = rddata_q;
  assign o_rdvalid      = rdvalid_q;

endmodule

// File: tb/tb_downsample_pack_fifo.sv
// Scoreboard bench for downsample_pack_fifo: a reference model predicts accepts, flags and
// read data; every cycle's outputs are compared one step after the clock edge.
module tb_downsample_pack_fifo;

  localparam int DI    = 128;
  localparam int DO    = 256;
  localparam int DP    = 10;
  localparam int AFT   = 1000;
  localparam int WORDS = 2 ** DP;

  logic          system_clk = 1'b0;
  logic          rst_n      = 1'b0;
  logic          i_wren     = 1'b0;
  logic [DI-1:0] i_wrdata   = '0;
  logic          i_flush    = 1'b0;
  logic          i_rden     = 1'b0;
  logic [DP:0]   almost_empty_threshold = 11'd3;
  logic          o_full, o_almost_full, o_half_pending, o_rdvalid, o_empty, o_almost_empty;
  logic [DO-1:0] o_rddata;
  logic [DP:0]   o_count;

  downsample_pack_fifo #(
    .DATA_IN(DI), .DATA_OUT(DO), .DEPTH(DP), .ALMOST_FULL_THRESHOLD(AFT)
  ) dut (
    .system_clk(system_clk), .rst_n(rst_n),
    .i_wren(i_wren), .i_wrdata(i_wrdata), .i_flush(i_flush),
    .o_full(o_full), .o_almost_full(o_almost_full), .o_half_pending(o_half_pending),
    .i_rden(i_rden), .o_rddata(o_rddata), .o_rdvalid(o_rdvalid),
    .o_empty(o_empty), .o_almost_empty(o_almost_empty),
    .almost_empty_threshold(almost_empty_threshold), .o_count(o_count)
  );

  always #5 system_clk = ~system_clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [DO-1:0] exp_q[$];
  int            m_count   = 0;
  logic          m_pend    = 1'b0;
  logic [DI-1:0] m_half    = '0;
  logic [DO-1:0] m_last    = '0;
  int            seq       = 0;
  int            reads_done = 0;

  task automatic chk(input string tag, input logic [DO-1:0] act, input logic [DO-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_half(output logic [DI-1:0] h);
    h = {$urandom(), $urandom(), $urandom(), 32'(seq)};
    seq++;
  endtask

  task automatic check_flags();
    chk("count",    DO'(o_count),        DO'(m_count));
    chk("full",     DO'(o_full),         DO'(m_count == WORDS));
    chk("empty",    DO'(o_empty),        DO'(m_count == 0));
    chk("afull",    DO'(o_almost_full),  DO'(m_count >= AFT));
    chk("aempty",   DO'(o_almost_empty), DO'(m_count < int'(almost_empty_threshold)));
    chk("pending",  DO'(o_half_pending), DO'(m_pend));
  endtask

  // One clock cycle: drive inputs, advance the model, check outputs after the edge.
  task automatic step(input logic wr, input logic [DI-1:0] wd, input logic rd, input logic fl);
    logic          wacc, racc, wword;
    logic [DO-1:0] wdat;
    i_wren = wr; i_wrdata = wd; i_rden = rd; i_flush = fl;
    wacc  = wr && (m_count != WORDS);
    racc  = rd && (m_count != 0);
    wword = 1'b0;
    wdat  = '0;
    if (wacc) begin
      if (m_pend) begin
        wword = 1'b1; wdat = {wd, m_half}; m_pend = 1'b0;
      end
`ifdef DOWNSAMPLE_FIFO_FLUSH_EN
      else if (fl) begin
        wword = 1'b1; wdat = {{DI{1'b0}}, wd};
      end
`endif
      else begin
        m_half = wd; m_pend = 1'b1;
      end
    end
`ifdef DOWNSAMPLE_FIFO_FLUSH_EN
    else if (fl && m_pend && (m_count != WORDS)) begin
      wword = 1'b1; wdat = {{DI{1'b0}}, m_half}; m_pend = 1'b0;
    end
`endif
    @(posedge system_clk);
    if (racc) m_last = exp_q.pop_front();
    if (wword) exp_q.push_back(wdat);
    m_count = m_count + int'(wword) - int'(racc);
    #1;
    chk("rdvalid", DO'(o_rdvalid), DO'(racc));
    chk("rddata", o_rddata, m_last);
    if (racc) begin
      reads_done++;
      $display("read #%0d data=%h count=%0d", reads_done, o_rddata, o_count);
    end
    check_flags();
  endtask

  task automatic wr_half(input logic rd);
    logic [DI-1:0] h;
    next_half(h);
    step(1'b1, h, rd, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (m_count != 0) step(1'b0, '0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic check_reset_values();
    chk("rst_rddata",  o_rddata,              '0);
    chk("rst_rdvalid", DO'(o_rdvalid),        '0);
    chk("rst_count",   DO'(o_count),          '0);
    chk("rst_full",    DO'(o_full),           '0);
    chk("rst_afull",   DO'(o_almost_full),    '0);
    chk("rst_pending", DO'(o_half_pending),   '0);
    chk("rst_empty",   DO'(o_empty),          DO'(1));
    chk("rst_aempty",  DO'(o_almost_empty),   DO'(almost_empty_threshold != 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DI-1:0] h;
    int cyc;

    // reset state
    repeat (2) @(posedge system_clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // basic pair 0xA/0xB then one read
    step(1'b1, DI'(128'hA), 1'b0, 1'b0);
    step(1'b1, DI'(128'hB), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pair_data", o_rddata, {DI'(128'hB), DI'(128'hA)});
    idle();

    // almost_empty threshold 3
    repeat (4) wr_half(1'b0);
    chk("aempty_at2", DO'(o_almost_empty), DO'(1));
    repeat (2) wr_half(1'b0);
    chk("aempty_at3", DO'(o_almost_empty), DO'(0));
    drain();

    // read in the same cycle the second half lands on an empty FIFO
    wr_half(1'b0);
    wr_half(1'b1);
    chk("same_cycle_norv", DO'(o_rdvalid), DO'(0));
    step(1'b0, '0, 1'b1, 1'b0);
    idle();

    // lone half and i_flush
    step(1'b1, DI'(128'h5), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, DI'(128'h7), 1'b0, 1'b1);
    wr_half(1'b0);
    drain();

    // fill to full, drop an extra write, then read+write while full
    for (int i = 0; i < 2 * WORDS; i++) wr_half(1'b0);
    chk("full_flag", DO'(o_full), DO'(1));
    wr_half(1'b0);
    chk("drop_pending", DO'(o_half_pending), DO'(0));
    wr_half(1'b1);
    chk("full_rd_wr_count", DO'(o_count), DO'(WORDS - 1));

    // random traffic across several pointer wraps
    cyc = 0;
    while (reads_done < 4 * WORDS && cyc < 30000) begin
      next_half(h);
      step(($urandom_range(0, 9) != 0), h, ($urandom_range(0, 99) < 46), 1'b0);
      cyc++;
    end
    chk("wrap_reads_done", DO'(reads_done >= 4 * WORDS), DO'(1));

    // asynchronous reset in the middle of a burst
    repeat (5) wr_half(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    m_count = 0; m_pend = 1'b0; m_half = '0; m_last = '0;
    @(posedge system_clk);
    #2;
    rst_n = 1'b1;
    wr_half(1'b0);
    wr_half(1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/downsample_pack_fifo.md
# downsample_pack_fifo

Narrow-to-wide packing FIFO on the write-back side of the accelerator. It accepts DATA_IN-bit half-words from the pooling/downsample datapath and pairs two consecutive halves into one DATA_OUT-bit word. It buffers the packed words in an internal dual-port RAM and returns them one full word per read to the wide memory writer. It performs the reverse width conversion of the upsample read FIFO: narrow write, wide read.

## Interface
Parameters:
- DATA_IN, 128, write half-word width
- DATA_OUT, 256, read word width; must equal 2*DATA_IN
- DEPTH, 10, word address width; capacity 2^DEPTH packed words
- ALMOST_FULL_THRESHOLD, 1000, word count at or above which o_almost_full asserts

Ports:
- system_clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- i_wren  in  1  write request for one half-word
- i_wrdata  in  DATA_IN  half-word data
- i_flush  in  1  push a pending lone half, zero-padded
- o_full  out  1  RAM holds 2^DEPTH words
- o_almost_full  out  1  o_count >= ALMOST_FULL_THRESHOLD
- o_half_pending  out  1  first half of a pair is held in the pack register
- i_rden  in  1  read request for one word
- o_rddata  out  DATA_OUT  registered read data
- o_rdvalid  out  1  o_rddata valid this cycle
- o_empty  out  1  no packed word stored
- o_almost_empty  out  1  o_count < almost_empty_threshold
- almost_empty_threshold  in  DEPTH+1  runtime threshold
- o_count  out  DEPTH+1  number of packed words stored

## Operation
Pack stage:
- Write accept: i_wren && !o_full.
- If o_half_pending=0, the accepted half goes to half_rg and o_half_pending sets.
- If o_half_pending=1, RAM[wrptr] <= {i_wrdata, half_rg}. The first half goes in the low bits. wrptr advances and o_half_pending clears.
- When o_full=1, i_wren is dropped. Neither half_rg nor o_half_pending changes.

Pointers:
- wrptr and rdptr are DEPTH bits wide and wrap from 2^DEPTH-1 to 0.
- o_count is DEPTH+1 bits: incremented on a word write, decremented on a read, unchanged when both happen in one cycle.

Read:
- Read accept: i_rden && !o_empty.
- On accept, RAM[rdptr] is registered into o_rddata, o_rdvalid pulses high for one cycle, and rdptr advances.
- When o_empty=1, i_rden is ignored: o_rdvalid stays 0 and o_rddata holds its value.

Status flags:
- o_full = (o_count == 2^DEPTH).
- o_empty = (o_count == 0).
- Both flags, o_almost_full and o_almost_empty are combinational from o_count.

Boundary cases:
- Read while full: allowed. A write completing a pair in the same cycle is refused, because o_full blocks the write.
- Write while empty: the read is not honoured that cycle. A word written in cycle N becomes readable from cycle N+1.
- Pending half while full: it stays in half_rg until space frees.
- Reset mid-operation: the pending half and all stored words are discarded.

## Timing
- Reset values:
  - o_rddata=0, o_rdvalid=0, o_count=0
  - o_full=0, o_almost_full=0, o_half_pending=0
  - o_empty=1
  - o_almost_empty = (almost_empty_threshold != 0)
- Read latency: 1 cycle. An accept at edge N drives o_rdvalid and o_rddata during cycle N+1.
- Write-to-read latency: a second half accepted at edge N makes o_empty=0 after edge N; it is readable at edge N+1 and its data appears in cycle N+2.
- Back-to-back reads: one word per cycle is sustained.
- Back-to-back writes: one half per cycle, which is one word per two cycles.
- Flags and o_count update on the same edge as the pointer change.

## Configuration
Macro DOWNSAMPLE_FIFO_FLUSH_EN.

With the macro defined:
- i_flush && o_half_pending && !o_full writes {DATA_IN'b0, half_rg}, advances wrptr and clears o_half_pending.
- i_flush while o_half_pending=0: no-op.
- i_flush together with an accepted i_wren:
  - If o_half_pending=1, the write completes the pair normally and the flush is ignored.
  - If o_half_pending=0, {DATA_IN'b0, i_wrdata} is written as one word directly.

Without the macro:
- i_flush is ignored.
- A lone half stays pending until its partner arrives.

## Test plan
- Reset, then write halves 0xA, 0xB, read once -> o_rdvalid high one cycle after the read, o_rddata = {0xB, 0xA} (low half 0xA); o_count sequence 0,0,1,0.
- Write 2*2^DEPTH halves with no reads -> o_full=1 with o_count=1024; one extra i_wren is dropped, o_half_pending stays 0; o_almost_full rose at count 1000.
- With the FIFO full, assert i_rden and i_wren together -> the read is returned and the write is refused. Continue writing and reading across 3 wraps -> data order preserved, no loss.
- Empty FIFO, read asserted in the same cycle the second half is accepted -> no o_rdvalid; a retry on the next cycle returns the word.
- FLUSH_EN: write 0x5, pulse i_flush -> word {0, 0x5} stored, o_half_pending=0. Simultaneous i_wren=0x7 and i_flush with no pending half -> word {0, 0x7} stored.
- Set almost_empty_threshold=3 and store 2 words -> o_almost_empty=1; store a 3rd -> 0. Assert rst_n low mid-burst -> all outputs return to their reset values asynchronously.
